friscv_proc_dispatch: RTL

Parametrised in-order dispatch stage for the friscv processing cluster. It generalises the fixed two-unit ALU/memfy pairing to NB_UNIT execution units behind a DEPTH-entry instruction queue. A 32-entry register scoreboard blocks RAW/WAW hazards, and fence entries drain all outstanding work before issue resumes. It sits between the decoder/control unit and the execution units, whose completions feed back to clear the scoreboard.

---
 rtl/friscv_proc_dispatch.sv | 132 +++++++++++++
 1 files changed

// File: rtl/friscv_proc_dispatch.sv
// In-order dispatch stage: DEPTH-entry instruction queue feeding NB_UNIT
// execution units, with a 32-entry register scoreboard blocking RAW/WAW
// hazards and fence entries that drain all outstanding writes.
module friscv_proc_dispatch #(
  parameter int unsigned NB_UNIT = 2,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned INST_W  = 64,
  localparam int unsigned UNIT_W = $clog2(NB_UNIT),
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 proc_en,
  output logic                 proc_ready,
  output logic                 proc_empty,
  output logic [CNT_W-1:0]     proc_count,
  input  logic [UNIT_W-1:0]    proc_unit,
  input  logic                 proc_fence,
  input  logic                 proc_rd_vld,
  input  logic [4:0]           proc_rd,
  input  logic [4:0]           proc_rs1,
  input  logic [4:0]           proc_rs2,
  input  logic [INST_W-1:0]    proc_instbus,
  output logic [NB_UNIT-1:0]   unit_en,
  input  logic [NB_UNIT-1:0]   unit_ready,
  output logic [INST_W-1:0]    unit_instbus,
  input  logic [NB_UNIT-1:0]   unit_done,
  input  logic [NB_UNIT*5-1:0] unit_done_rd
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned UNIT_W1 = UNIT_W + 1;
  localparam logic [UNIT_W:0]  NB_UNIT_V = UNIT_W1'(NB_UNIT);
  localparam logic [CNT_W-1:0] DEPTH_V   = CNT_W'(DEPTH);

  typedef struct packed {
    logic [UNIT_W-1:0] unit;
    logic              fence;
    logic              rd_vld;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [INST_W-1:0] instbus;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [31:0]       pending;
  logic [31:0]       pending_nxt;
  logic [31:0]       set_mask;
  logic [31:0]       clr_mask;

  entry_t            head;
  logic              not_empty;
  logic              unit_ok;
  logic              hazard;
  logic              issue;
  logic              accepted;
  logic              push;
  logic              pop;

  assign head      = mem[rd_ptr];
  assign not_empty = (count != '0);
  assign unit_ok   = ({1'b0, head.unit} < NB_UNIT_V);
  assign hazard    = pending[head.rs1] | pending[head.rs2] |
                     (head.rd_vld & pending[head.rd]);
  assign issue     = not_empty & ~head.fence & unit_ok & ~hazard;
  assign accepted  = |(unit_en & unit_ready);
  assign push      = proc_en & proc_ready;

  // Head retires: fence once drained, discard for out-of-range unit, else on accept
  always_comb begin
    pop = 1'b0;
    if (not_empty) begin
      if (head.fence)   pop = (pending == '0);
      else if (!unit_ok) pop = 1'b1;
      else              pop = accepted;
    end
  end

  // One-hot issue strobe toward the head's target unit
  always_comb begin
    unit_en = '0;
    if (issue) unit_en = NB_UNIT'(1) << head.unit;
  end

  assign unit_instbus = not_empty ? head.instbus : '0;
  assign proc_count   = count;
  assign proc_ready   = (count < DEPTH_V);
  assign proc_empty   = (count == '0) & (pending == '0);

  // Scoreboard update: completions clear, issue sets (set wins), r0 never pending
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    for (int unsigned i = 0; i < NB_UNIT; i++) begin
      if (unit_done[i]) clr_mask[unit_done_rd[5*i +: 5]] = 1'b1;
    end
    if (accepted && head.rd_vld && (head.rd != 5'd0)) set_mask[head.rd] = 1'b1;
    pending_nxt = ((pending & ~clr_mask) | set_mask) & ~32'd1;
  end

  // Queue payload storage, written on accepted push
  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr] <= {proc_unit, proc_fence, proc_rd_vld, proc_rd,
                      proc_rs1, proc_rs2, proc_instbus};
    end
  end

  // Pointers, occupancy and scoreboard state
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pending <= '0;
    end else begin
      pending <= pending_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
